// File: rtl/dmem_pkg.sv
// Shared types for the data-memory coalescer: FSM state encoding and lane index sizing.
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RD_WAIT,
        RD_DRAIN,
        WR_WAIT,
        WR_DRAIN,
        RESPOND
    } state_t;

    // Width of a lane index; a single lane still needs one bit.
    function automatic int lane_idx_bits(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/dmem_match_unit.sv
// Combinational leader pick and same-address match mask; zero latency, no flow control.
// With DMEM_COALESCE_EN: reads lead lowest, writes highest, match by address; otherwise leader only, lowest first.
module dmem_match_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int NUM_LANES = 4,
    parameter int IDXW      = lane_idx_bits(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0]           i_pending,
    input  logic [NUM_LANES*ADDR_BITS-1:0] i_addr,
    input  logic                           i_is_write,
    output logic [IDXW-1:0]                o_leader,
    output logic [NUM_LANES-1:0]           o_match
);

`ifdef DMEM_COALESCE_EN
    localparam bit LP_COALESCE = 1'b1;
`else
    localparam bit LP_COALESCE = 1'b0;
`endif

    logic [ADDR_BITS-1:0] w_lead_addr;

    // Writes lead from the top so the surviving data is the last writer's.
    always_comb begin
        o_leader = '0;
        if (i_is_write && LP_COALESCE) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (i_pending[i]) o_leader = IDXW'(i);
            end
        end else begin
            for (int i = NUM_LANES - 1; i >= 0; i--) begin
                if (i_pending[i]) o_leader = IDXW'(i);
            end
        end
    end

    assign w_lead_addr = i_addr[int'(o_leader)*ADDR_BITS +: ADDR_BITS];

    always_comb begin
        o_match = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i_pending[i] && (i_addr[i*ADDR_BITS +: ADDR_BITS] == w_lead_addr)
                && (LP_COALESCE || (IDXW'(i) == o_leader))) begin
                o_match[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_coalescer.sv
// Batches LSU lane requests, merges same-address lanes (DMEM_COALESCE_EN) and issues them serially; >=3 cycles per merged txn.
// Controller valid held until ready, next request only after ready falls; lanes all released together in RESPOND.
module dmem_coalescer
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int NUM_LANES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           lane_read_valid,
    input  logic [NUM_LANES*ADDR_BITS-1:0] lane_read_address,
    output logic [NUM_LANES-1:0]           lane_read_ready,
    output logic [NUM_LANES*DATA_BITS-1:0] lane_read_data,
    input  logic [NUM_LANES-1:0]           lane_write_valid,
    input  logic [NUM_LANES*ADDR_BITS-1:0] lane_write_address,
    input  logic [NUM_LANES*DATA_BITS-1:0] lane_write_data,
    output logic [NUM_LANES-1:0]           lane_write_ready,
    output logic                           mem_read_valid,
    output logic [ADDR_BITS-1:0]           mem_read_address,
    input  logic                           mem_read_ready,
    input  logic [DATA_BITS-1:0]           mem_read_data,
    output logic                           mem_write_valid,
    output logic [ADDR_BITS-1:0]           mem_write_address,
    output logic [DATA_BITS-1:0]           mem_write_data,
    input  logic                           mem_write_ready
);

    localparam int IDXW = lane_idx_bits(NUM_LANES);

    state_t                         r_state;
    state_t                         w_next;
    logic [NUM_LANES-1:0]           r_rd_batch;
    logic [NUM_LANES-1:0]           r_wr_batch;
    logic [NUM_LANES-1:0]           r_pend_rd;
    logic [NUM_LANES-1:0]           r_pend_wr;
    logic [NUM_LANES-1:0]           r_match;
    logic [NUM_LANES-1:0]           r_rd_rdy;
    logic [NUM_LANES-1:0]           r_wr_rdy;
    logic [NUM_LANES*DATA_BITS-1:0] r_rdata;
    logic                           r_mrv;
    logic [ADDR_BITS-1:0]           r_mra;
    logic                           r_mwv;
    logic [ADDR_BITS-1:0]           r_mwa;
    logic [DATA_BITS-1:0]           r_mwd;

    logic                           w_any_valid;
    logic                           w_sel_wr;
    logic [NUM_LANES-1:0]           w_sel_pend;
    logic [NUM_LANES*ADDR_BITS-1:0] w_sel_addr;
    logic [IDXW-1:0]                w_leader;
    logic [NUM_LANES-1:0]           w_match;

    assign w_any_valid = |(lane_read_valid | lane_write_valid);
    // Reads drain first; writes are only considered once no read is pending.
    assign w_sel_wr    = ~|r_pend_rd;
    assign w_sel_pend  = w_sel_wr ? r_pend_wr : r_pend_rd;
    assign w_sel_addr  = w_sel_wr ? lane_write_address : lane_read_address;

    dmem_match_unit #(
        .ADDR_BITS (ADDR_BITS),
        .NUM_LANES (NUM_LANES),
        .IDXW      (IDXW)
    ) u_match (
        .i_pending  (w_sel_pend),
        .i_addr     (w_sel_addr),
        .i_is_write (w_sel_wr),
        .o_leader   (w_leader),
        .o_match    (w_match)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_any_valid) w_next = SELECT;
            SELECT: begin
                if (|r_pend_rd)      w_next = RD_WAIT;
                else if (|r_pend_wr) w_next = WR_WAIT;
                else                 w_next = RESPOND;
            end
            RD_WAIT:  if (mem_read_ready)   w_next = RD_DRAIN;
            RD_DRAIN: if (!mem_read_ready)  w_next = SELECT;
            WR_WAIT:  if (mem_write_ready)  w_next = WR_DRAIN;
            WR_DRAIN: if (!mem_write_ready) w_next = SELECT;
            RESPOND:  if (~|r_rd_rdy && ~|r_wr_rdy) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_batch <= '0;
            r_wr_batch <= '0;
            r_pend_rd  <= '0;
            r_pend_wr  <= '0;
            r_match    <= '0;
            r_rd_rdy   <= '0;
            r_wr_rdy   <= '0;
            r_rdata    <= '0;
            r_mrv      <= 1'b0;
            r_mra      <= '0;
            r_mwv      <= 1'b0;
            r_mwa      <= '0;
            r_mwd      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_rd_batch <= lane_read_valid;
                        r_wr_batch <= lane_write_valid & ~lane_read_valid;
                        r_pend_rd  <= lane_read_valid;
                        r_pend_wr  <= lane_write_valid & ~lane_read_valid;
                    end
                end
                SELECT: begin
                    r_match <= w_match;
                    if (|r_pend_rd) begin
                        r_mrv <= 1'b1;
                        r_mra <= lane_read_address[int'(w_leader)*ADDR_BITS +: ADDR_BITS];
                    end else if (|r_pend_wr) begin
                        r_mwv <= 1'b1;
                        r_mwa <= lane_write_address[int'(w_leader)*ADDR_BITS +: ADDR_BITS];
                        r_mwd <= lane_write_data[int'(w_leader)*DATA_BITS +: DATA_BITS];
                    end else begin
                        r_rd_rdy <= r_rd_batch;
                        r_wr_rdy <= r_wr_batch;
                    end
                end
                RD_WAIT: begin
                    if (mem_read_ready) begin
                        r_mrv     <= 1'b0;
                        r_pend_rd <= r_pend_rd & ~r_match;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (r_match[i]) r_rdata[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        end
                    end
                end
                WR_WAIT: begin
                    if (mem_write_ready) begin
                        r_mwv     <= 1'b0;
                        r_pend_wr <= r_pend_wr & ~r_match;
                    end
                end
                RESPOND: begin
                    r_rd_rdy <= r_rd_rdy & lane_read_valid;
                    r_wr_rdy <= r_wr_rdy & lane_write_valid;
                end
                default: ;
            endcase
        end
    end

    assign lane_read_ready   = r_rd_rdy;
    assign lane_write_ready  = r_wr_rdy;
    assign lane_read_data    = r_rdata;
    assign mem_read_valid    = r_mrv;
    assign mem_read_address  = r_mra;
    assign mem_write_valid   = r_mwv;
    assign mem_write_address = r_mwa;
    assign mem_write_data    = r_mwd;

endmodule

// File: tb/tb_dmem_coalescer.sv
// Directed bench for dmem_coalescer with a behavioural memory controller; expectations follow DMEM_COALESCE_EN.
module tb_dmem_coalescer;

`ifdef DMEM_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  lane_read_valid;
    logic [31:0] lane_read_address;
    logic [3:0]  lane_read_ready;
    logic [31:0] lane_read_data;
    logic [3:0]  lane_write_valid;
    logic [31:0] lane_write_address;
    logic [31:0] lane_write_data;
    logic [3:0]  lane_write_ready;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [7:0]  mem_read_data;
    logic        mem_write_valid;
    logic [7:0]  mem_write_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_ready;

    dmem_coalescer #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_LANES(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .lane_read_valid    (lane_read_valid),
        .lane_read_address  (lane_read_address),
        .lane_read_ready    (lane_read_ready),
        .lane_read_data     (lane_read_data),
        .lane_write_valid   (lane_write_valid),
        .lane_write_address (lane_write_address),
        .lane_write_data    (lane_write_data),
        .lane_write_ready   (lane_write_ready),
        .mem_read_valid     (mem_read_valid),
        .mem_read_address   (mem_read_address),
        .mem_read_ready     (mem_read_ready),
        .mem_read_data      (mem_read_data),
        .mem_write_valid    (mem_write_valid),
        .mem_write_address  (mem_write_address),
        .mem_write_data     (mem_write_data),
        .mem_write_ready    (mem_write_ready)
    );

    always #5 clk = ~clk;

    // Controller model state; ops entries are {is_write, addr, data}.
    logic [7:0]  mem [256];
    logic [16:0] ops [$];
    int          rd_lat = 1;
    int          hold   = 1;
    int          overlap;
    int          rd_cnt, wr_cnt, rd_hcnt, wr_hcnt;
    bit          rd_hold, wr_hold;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          base;
    logic [3:0]  got_rr, got_wr;
    bit          timed_out;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h33;
        mem[8'h10] = 8'h5A;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = '0;
        overlap = 0;
        rd_cnt = 0; wr_cnt = 0; rd_hcnt = 0; wr_hcnt = 0;
        rd_hold = 1'b0; wr_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_read_ready  = 1'b0;
                mem_write_ready = 1'b0;
                rd_cnt = 0; wr_cnt = 0;
                rd_hold = 1'b0; wr_hold = 1'b0;
            end else begin
                if (mem_read_valid) begin
                    if (rd_hold) overlap++;
                    if (!mem_read_ready) begin
                        if (rd_cnt >= rd_lat) begin
                            mem_read_ready = 1'b1;
                            mem_read_data  = mem[mem_read_address];
                            ops.push_back({1'b0, mem_read_address, mem[mem_read_address]});
                            rd_cnt = 0;
                        end else rd_cnt++;
                    end
                end else if (mem_read_ready) begin
                    if (!rd_hold) begin rd_hold = 1'b1; rd_hcnt = hold; end
                    if (rd_hcnt == 0) begin mem_read_ready = 1'b0; rd_hold = 1'b0; end
                    else rd_hcnt--;
                end
                if (mem_write_valid) begin
                    if (wr_hold) overlap++;
                    if (!mem_write_ready) begin
                        if (wr_cnt >= rd_lat) begin
                            mem_write_ready = 1'b1;
                            mem[mem_write_address] = mem_write_data;
                            ops.push_back({1'b1, mem_write_address, mem_write_data});
                            wr_cnt = 0;
                        end else wr_cnt++;
                    end
                end else if (mem_write_ready) begin
                    if (!wr_hold) begin wr_hold = 1'b1; wr_hcnt = hold; end
                    if (wr_hcnt == 0) begin mem_write_ready = 1'b0; wr_hold = 1'b0; end
                    else wr_hcnt--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_dir(input int from, input bit dir);
        int c = 0;
        for (int i = from; i < ops.size(); i++) begin
            logic [16:0] e;
            e = ops[i];
            if (e[16] == dir) c++;
        end
        return c;
    endfunction

    function automatic logic [16:0] op_at(input int idx);
        if (idx < ops.size()) return ops[idx];
        return 17'h1FFFF;
    endfunction

    task automatic run_batch(input logic [3:0] rv, input logic [31:0] ra,
                             input logic [3:0] wv, input logic [31:0] wa, input logic [31:0] wd);
        int k;
        base = ops.size();
        @(negedge clk);
        lane_read_valid    = rv;
        lane_read_address  = ra;
        lane_write_valid   = wv;
        lane_write_address = wa;
        lane_write_data    = wd;
        k = 0;
        while (k < 400 && lane_read_ready == 4'b0 && lane_write_ready == 4'b0) begin
            @(negedge clk);
            k++;
        end
        timed_out = (lane_read_ready == 4'b0 && lane_write_ready == 4'b0);
        got_rr = lane_read_ready;
        got_wr = lane_write_ready;
        lane_read_valid  = '0;
        lane_write_valid = '0;
        k = 0;
        while (k < 50 && (lane_read_ready != 4'b0 || lane_write_ready != 4'b0)) begin
            @(negedge clk);
            k++;
        end
        if (lane_read_ready != 4'b0 || lane_write_ready != 4'b0) timed_out = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [16:0] op;
        logic [7:0]  e2 [4];
        int          n2;
        int          k;

        reset = 1'b1;
        lane_read_valid = '0; lane_read_address = '0;
        lane_write_valid = '0; lane_write_address = '0; lane_write_data = '0;
        #3;
        chk("rst_rd_ready", lane_read_ready, 4'h0);
        chk("rst_wr_ready", lane_write_ready, 4'h0);
        chk("rst_rd_data", lane_read_data, 32'h0);
        chk("rst_mem_rv", mem_read_valid, 1'b0);
        chk("rst_mem_wv", mem_write_valid, 1'b0);
        chk("rst_mem_wd", mem_write_data, 8'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Four lanes, one address.
        run_batch(4'hF, {4{8'h10}}, 4'h0, 32'h0, 32'h0);
        chk("t1_done", timed_out, 1'b0);
        chk("t1_rd_ready", got_rr, 4'hF);
        chk("t1_wr_ready", got_wr, 4'h0);
        chk("t1_rd_count", count_dir(base, 1'b0), COAL ? 1 : 4);
        chk("t1_wr_count", count_dir(base, 1'b1), 0);
        chk("t1_data", lane_read_data, 32'h5A5A5A5A);

        // Lanes 0 and 2 share address 0x01.
        if (COAL) begin
            e2[0] = 8'h01; e2[1] = 8'h02; e2[2] = 8'h03; e2[3] = 8'h00; n2 = 3;
        end else begin
            e2[0] = 8'h01; e2[1] = 8'h02; e2[2] = 8'h01; e2[3] = 8'h03; n2 = 4;
        end
        run_batch(4'hF, {8'h03, 8'h01, 8'h02, 8'h01}, 4'h0, 32'h0, 32'h0);
        chk("t2_done", timed_out, 1'b0);
        chk("t2_rd_count", count_dir(base, 1'b0), n2);
        for (int i = 0; i < n2; i++) begin
            op = op_at(base + i);
            chk($sformatf("t2_rd_addr%0d", i), op[15:8], e2[i]);
        end
        chk("t2_data", lane_read_data, 32'h30323132);
        chk("t2_rd_ready", got_rr, 4'hF);

        // Lanes 1 and 3 store to 0x20; the higher lane's data must survive.
        run_batch(4'h0, 32'h0, 4'b1010, {8'h20, 8'h00, 8'h20, 8'h00}, {8'hBB, 8'h00, 8'hAA, 8'h00});
        chk("t3_done", timed_out, 1'b0);
        chk("t3_wr_ready", got_wr, 4'b1010);
        chk("t3_rd_ready", got_rr, 4'h0);
        chk("t3_wr_count", count_dir(base, 1'b1), COAL ? 1 : 2);
        op = op_at(base);
        chk("t3_first_wdata", op[7:0], COAL ? 8'hBB : 8'hAA);
        chk("t3_mem", mem[8'h20], 8'hBB);

        // Read and write to the same address in one batch.
        run_batch(4'b0001, 32'h00000004, 4'b0100, 32'h00040000, 32'h00770000);
        chk("t4_done", timed_out, 1'b0);
        chk("t4_rd_ready", got_rr, 4'b0001);
        chk("t4_wr_ready", got_wr, 4'b0100);
        chk("t4_op_count", ops.size() - base, 2);
        op = op_at(base);
        chk("t4_first_is_read", op[16:8], {1'b0, 8'h04});
        op = op_at(base + 1);
        chk("t4_second_is_write", op[16:0], {1'b1, 8'h04, 8'h77});
        chk("t4_old_data", lane_read_data, 32'h30323137);
        chk("t4_mem", mem[8'h04], 8'h77);

        // Controller lingers with ready high for three cycles.
        hold = 3;
        run_batch(4'b0011, 32'h00000605, 4'h0, 32'h0, 32'h0);
        hold = 1;
        chk("t5_done", timed_out, 1'b0);
        chk("t5_overlap", overlap, 0);
        chk("t5_rd_count", count_dir(base, 1'b0), 2);
        op = op_at(base + 1);
        chk("t5_second_addr", op[15:8], 8'h06);
        chk("t5_data", lane_read_data, 32'h30323536);

        // Reset while the controller is still working on a read.
        rd_lat = 20;
        @(negedge clk);
        lane_read_valid   = 4'b0001;
        lane_read_address = 32'h00000007;
        k = 0;
        while (k < 50 && !mem_read_valid) begin
            @(negedge clk);
            k++;
        end
        chk("t6_pre_valid", mem_read_valid, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_rv", mem_read_valid, 1'b0);
        chk("t6_rst_ra", mem_read_address, 8'h00);
        chk("t6_rst_data", lane_read_data, 32'h0);
        chk("t6_rst_rd_ready", lane_read_ready, 4'h0);
        lane_read_valid = '0;
        rd_lat = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_batch(4'b1000, 32'h08000000, 4'h0, 32'h0, 32'h0);
        chk("t6_done", timed_out, 1'b0);
        chk("t6_rd_ready", got_rr, 4'b1000);
        chk("t6_data", lane_read_data, 32'h3B000000);
        chk("t6_rd_count", count_dir(base, 1'b0), 1);

        chk("final_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
